uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing the single UART TX path (TX FIFO -> uart_tx)
//  between NUM_REQ_P byte-stream producers (e.g. packet_parser echo, ALU result engine).
//  Grant is held for a whole packet (through the beat flagged last) so packets never interleave.
//  Sits between the producers and the TX FIFO write port; downstream side is valid/ready.
// PARAMETERS
//  NUM_REQ_P     2    number of requesters, >=1
//  DATA_WIDTH_P  8    byte width, matches uart_tx DATA_WIDTH
//  TIMEOUT_P     255  stall cycles before forced release (used only with UART_TX_ARB_TIMEOUT_EN), >=1
// PORTS
//  clk_i        in   1                        clock
//  rst_ni       in   1                        asynchronous reset, active-low
//  req_valid_i  in   NUM_REQ_P                per-requester beat valid
//  req_data_i   in   NUM_REQ_P*DATA_WIDTH_P   per-requester byte, req r at [r*DATA_WIDTH_P +: DATA_WIDTH_P]
//  req_last_i   in   NUM_REQ_P                per-requester last beat of packet
//  req_ready_o  out  NUM_REQ_P                per-requester ready; only granted bit can be 1
//  tx_data_o    out  DATA_WIDTH_P             byte to TX FIFO
//  tx_valid_o   out  1                        to TX FIFO valid_i
//  tx_ready_i   in   1                        from TX FIFO ready_o
//  grant_o      out  NUM_REQ_P                one-hot current grant, 0 when idle
//  busy_o       out  1                        1 while in GRANT
//  timeout_o    out  1                        1-cycle pulse on forced release
// BEHAVIOUR
//  - Reset (rst_ni=0, async): state=IDLE, grant_o=0, rr pointer=0, stall counter=0, timeout_o=0.
//    Outputs during/after reset: tx_valid_o=0, tx_data_o=0, req_ready_o=0, busy_o=0.
//  - FSM IDLE: if |req_valid_i, select first valid index scanning ptr, ptr+1, ... (mod NUM_REQ_P);
//    register grant, go GRANT next cycle. Arbitration latency 1 cycle; no beat moves in IDLE.
//  - FSM GRANT (index g): combinational pass-through, zero latency:
//    tx_valid_o=req_valid_i[g], tx_data_o=req_data_i[g], req_ready_o[g]=tx_ready_i, others 0.
//    Beat transfers when req_valid_i[g] & tx_ready_i.
//    Transfer with req_last_i[g]=1 -> IDLE, ptr <= (g+1) mod NUM_REQ_P (N-1 wraps to 0).
//  - Back-to-back packets: exactly one idle bubble cycle between last beat and next grant.
//  - Requests arriving in GRANT wait; losers hold valid (producer's AXI-style obligation).
//  - Granted source dropping valid mid-packet: grant held, tx_valid_o=0, nothing forwarded.
//  - tx_data_o=0 whenever tx_valid_o=0 (no stale data exposure).
//  - NUM_REQ_P=1: degenerates to pass-through plus 1-cycle arbitration bubble per packet.
//  - Reset mid-packet: grant dropped immediately; partial packet is not completed (system
//    reset resets FIFO/uart_tx together).
// CONFIGURATION
//  UART_TX_ARB_TIMEOUT_EN defined: stall counter ($clog2(TIMEOUT_P+1) bits) increments each GRANT
//    cycle with req_valid_i[g]=0, clears on valid high or on entering GRANT. Counter reaching
//    TIMEOUT_P: next cycle IDLE, ptr <= g+1, timeout_o=1 for one cycle. Downstream back-pressure
//    (valid=1, ready=0) never counts.
//  Not defined: no counter, grant held indefinitely, timeout_o tied 0.
// TESTING
//  1 reset: rst_ni=0 with all req_valid_i=1 -> all outputs 0; release -> req0 granted 1 cycle later.
//  2 contention: req0 sends 3 bytes (0x11,0x22,0x33 last), req1 sends 0xAA last concurrently
//    -> tx order 11,22,33,(1 bubble),AA; req1 ready stays 0 until grant.
//  3 fairness: both continuously request 1-byte packets -> grant alternates 0,1,0,1; ptr wraps 1->0.
//  4 back-pressure: tx_ready_i=0 for 10 cycles mid-packet -> data held stable, no loss, grant kept,
//    timeout_o stays 0 even with TIMEOUT_P=4 and macro on.
//  5 source stall: req0 drops valid after byte 1, TIMEOUT_P=4, macro on -> timeout_o pulse after 4
//    stall cycles, req1 granted next; macro off -> grant held, timeout_o=0.
//  6 async reset mid-packet: assert rst_ni between beats -> grant_o=0, tx_valid_o=0 same cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin arbiter in front of the UART TX FIFO.
// A grant is held from the first beat through the beat flagged last, so packets
// never interleave. Data path is a zero-latency pass-through of the granted source.
// Optional stall timeout (forced release of a silent source) is enabled by
// defining the macro UART_TX_ARB_TIMEOUT_EN; without it the grant is held indefinitely.
module uart_tx_arbiter #(
  parameter int NUM_REQ_P    = 2,
  parameter int DATA_WIDTH_P = 8,
  parameter int TIMEOUT_P    = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_REQ_P-1:0]              req_valid_i,
  input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0] req_data_i,
  input  logic [NUM_REQ_P-1:0]              req_last_i,
  output logic [NUM_REQ_P-1:0]              req_ready_o,
  output logic [DATA_WIDTH_P-1:0]           tx_data_o,
  output logic                              tx_valid_o,
  input  logic                              tx_ready_i,
  output logic [NUM_REQ_P-1:0]              grant_o,
  output logic                              busy_o,
  output logic                              timeout_o
);

  localparam int PTR_W = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic               timeout_q, timeout_d;

  logic               sel_found_s;
  logic [PTR_W-1:0]   sel_idx_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic               valid_g_s;
  logic               last_g_s;
  logic               xfer_s;
  logic [DATA_WIDTH_P-1:0] data_g_s;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_P + 1);
  logic [CNT_W-1:0]   stall_q, stall_d;
`endif

  // Round-robin pick: first valid requester scanning from the pointer upward, wrapping.
  always_comb begin
    int cand;
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = 0; i < NUM_REQ_P; i++) begin
      cand = int'(rr_ptr_q) + i;
      cand = (cand >= NUM_REQ_P) ? (cand - NUM_REQ_P) : cand;
      if (!sel_found_s && req_valid_i[PTR_W'(cand)]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = PTR_W'(cand);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Granted-source views and the pointer value used after a release.
  always_comb begin
    valid_g_s  = req_valid_i[gidx_q];
    last_g_s   = req_last_i[gidx_q];
    data_g_s   = req_data_i[int'(gidx_q)*DATA_WIDTH_P +: DATA_WIDTH_P];
    xfer_s     = (state_q == ST_GRANT) && valid_g_s && tx_ready_i;
    next_ptr_s = (int'(gidx_q) == NUM_REQ_P - 1) ? '0 : (gidx_q + {{(PTR_W-1){1'b0}}, 1'b1});
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until the last beat (or a stall timeout).
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gidx_d    = gidx_q;
    timeout_d = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    stall_d   = stall_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_d = ST_GRANT;
          gidx_d  = sel_idx_s;
`ifdef UART_TX_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (xfer_s && last_g_s) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr_s;
`ifdef UART_TX_ARB_TIMEOUT_EN
          stall_d  = '0;
        end else if (!valid_g_s) begin
          // Only a silent source counts; downstream back-pressure never does.
          if (stall_q == CNT_W'(TIMEOUT_P - 1)) begin
            state_d   = ST_IDLE;
            rr_ptr_d  = next_ptr_s;
            timeout_d = 1'b1;
            stall_d   = '0;
          end else begin
            stall_d   = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          stall_d = '0;
`else
        end else begin
          state_d = ST_GRANT;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer, grant index and timeout pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gidx_q    <= '0;
      timeout_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stall_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gidx_q    <= gidx_d;
      timeout_q <= timeout_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stall_q   <= stall_d;
`endif
    end
  end

  // Zero-latency pass-through of the granted source; data forced to 0 when not valid.
  always_comb begin
    busy_o      = (state_q == ST_GRANT);
    grant_o     = '0;
    req_ready_o = '0;
    tx_valid_o  = busy_o && valid_g_s;
    tx_data_o   = tx_valid_o ? data_g_s : '0;
    if (busy_o) begin
      grant_o[gidx_q]     = 1'b1;
      req_ready_o[gidx_q] = tx_ready_i;
    end else begin
      grant_o     = '0;
      req_ready_o = '0;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ_P=2, DATA_WIDTH_P=8, TIMEOUT_P=4).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_uart_tx_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic [1:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [1:0]  grant_o;
  logic        busy_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(
    .NUM_REQ_P   (2),
    .DATA_WIDTH_P(8),
    .TIMEOUT_P   (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
    .req_last_i (req_last_i),
    .req_ready_o(req_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst_ni      = 1'b0;
    req_valid_i = 2'b00;
    req_data_i  = 16'h0000;
    req_last_i  = 2'b00;
    tx_ready_i  = 1'b1;
    step;
    step;
    rst_ni = 1'b1;
  endtask

  initial begin
    // 1: reset with both requesting, then release
    rst_ni      = 1'b0;
    req_valid_i = 2'b11;
    req_data_i  = 16'hA55A;
    req_last_i  = 2'b11;
    tx_ready_i  = 1'b1;
    step;
    step;
    check("rst_grant", {30'd0, grant_o}, 32'd0);
    check("rst_txvalid", {31'd0, tx_valid_o}, 32'd0);
    check("rst_txdata", {24'd0, tx_data_o}, 32'd0);
    check("rst_ready", {30'd0, req_ready_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    rst_ni = 1'b1;
    settle;
    check("rel_idle_grant", {30'd0, grant_o}, 32'd0);
    step;
    check("rel_grant0", {30'd0, grant_o}, 32'd1);
    check("rel_data0", {24'd0, tx_data_o}, 32'h5A);
    check("rel_busy", {31'd0, busy_o}, 32'd1);

    // 2: contention, req0 3-byte packet vs req1 1-byte packet
    do_reset;
    req_valid_i = 2'b11;
    req_data_i  = {8'hAA, 8'h11};
    req_last_i  = 2'b10;
    settle;
    check("c_idle_txvalid", {31'd0, tx_valid_o}, 32'd0);
    check("c_idle_ready", {30'd0, req_ready_o}, 32'd0);
    step;
    check("c_b1_data", {24'd0, tx_data_o}, 32'h11);
    check("c_b1_ready", {30'd0, req_ready_o}, 32'd1);
    step;
    req_data_i = {8'hAA, 8'h22};
    settle;
    check("c_b2_data", {24'd0, tx_data_o}, 32'h22);
    check("c_b2_ready", {30'd0, req_ready_o}, 32'd1);
    step;
    req_data_i = {8'hAA, 8'h33};
    req_last_i = 2'b11;
    settle;
    check("c_b3_data", {24'd0, tx_data_o}, 32'h33);
    step;
    req_valid_i = 2'b10;
    settle;
    check("c_bubble_valid", {31'd0, tx_valid_o}, 32'd0);
    check("c_bubble_grant", {30'd0, grant_o}, 32'd0);
    check("c_bubble_data", {24'd0, tx_data_o}, 32'd0);
    step;
    check("c_aa_grant", {30'd0, grant_o}, 32'd2);
    check("c_aa_data", {24'd0, tx_data_o}, 32'hAA);
    check("c_aa_ready", {30'd0, req_ready_o}, 32'd2);
    step;
    req_valid_i = 2'b00;
    settle;
    check("c_end_busy", {31'd0, busy_o}, 32'd0);

    // 3: fairness, both streaming 1-byte packets
    do_reset;
    req_valid_i = 2'b11;
    req_data_i  = {8'h02, 8'h01};
    req_last_i  = 2'b11;
    begin
      logic [1:0] exp_seq [7];
      exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      for (int k = 0; k < 7; k++) begin
        step;
        check($sformatf("fair_grant%0d", k), {30'd0, grant_o}, {30'd0, exp_seq[k]});
      end
    end
    req_valid_i = 2'b00;

    // 4: downstream back-pressure for 10 cycles mid-packet
    do_reset;
    req_valid_i = 2'b11;
    req_data_i  = {8'hEE, 8'h3C};
    req_last_i  = 2'b10;
    step;
    check("bp_b1_data", {24'd0, tx_data_o}, 32'h3C);
    step;
    req_data_i = {8'hEE, 8'h4D};
    req_last_i = 2'b11;
    tx_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      settle;
      check($sformatf("bp_data%0d", k), {24'd0, tx_data_o}, 32'h4D);
      check($sformatf("bp_grant%0d", k), {30'd0, grant_o}, 32'd1);
      check($sformatf("bp_ready%0d", k), {30'd0, req_ready_o}, 32'd0);
      check($sformatf("bp_to%0d", k), {31'd0, timeout_o}, 32'd0);
      step;
    end
    tx_ready_i = 1'b1;
    settle;
    check("bp_resume_ready", {30'd0, req_ready_o}, 32'd1);
    check("bp_resume_data", {24'd0, tx_data_o}, 32'h4D);
    step;
    req_valid_i = 2'b00;
    settle;
    check("bp_done_grant", {30'd0, grant_o}, 32'd0);

    // 5: granted source goes silent after its first byte
    do_reset;
    req_valid_i = 2'b11;
    req_data_i  = {8'h88, 8'h77};
    req_last_i  = 2'b10;
    step;
    check("st_b1_data", {24'd0, tx_data_o}, 32'h77);
    step;
    req_valid_i = 2'b10;
    settle;
    check("st_s1_txvalid", {31'd0, tx_valid_o}, 32'd0);
    check("st_s1_txdata", {24'd0, tx_data_o}, 32'd0);
    check("st_s1_grant", {30'd0, grant_o}, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      step;
      check($sformatf("st_s%0d_grant", k), {30'd0, grant_o}, 32'd1);
      check($sformatf("st_s%0d_to", k), {31'd0, timeout_o}, 32'd0);
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    step;
    check("st_to_pulse", {31'd0, timeout_o}, 32'd1);
    check("st_to_grant", {30'd0, grant_o}, 32'd0);
    check("st_to_busy", {31'd0, busy_o}, 32'd0);
    step;
    check("st_to_clear", {31'd0, timeout_o}, 32'd0);
    check("st_req1_grant", {30'd0, grant_o}, 32'd2);
    check("st_req1_data", {24'd0, tx_data_o}, 32'h88);
`else
    for (int k = 0; k < 10; k++) begin
      step;
      check($sformatf("st_hold_grant%0d", k), {30'd0, grant_o}, 32'd1);
      check($sformatf("st_hold_to%0d", k), {31'd0, timeout_o}, 32'd0);
    end
`endif
    req_valid_i = 2'b00;

    // 6: asynchronous reset between beats
    do_reset;
    req_valid_i = 2'b01;
    req_data_i  = {8'h00, 8'h99};
    req_last_i  = 2'b00;
    step;
    check("ar_grant_before", {30'd0, grant_o}, 32'd1);
    step;
    rst_ni = 1'b0;
    settle;
    check("ar_grant", {30'd0, grant_o}, 32'd0);
    check("ar_txvalid", {31'd0, tx_valid_o}, 32'd0);
    check("ar_txdata", {24'd0, tx_data_o}, 32'd0);
    check("ar_busy", {31'd0, busy_o}, 32'd0);
    step;
    rst_ni = 1'b1;
    step;
    check("ar_regrant", {30'd0, grant_o}, 32'd1);
    req_valid_i = 2'b00;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
